mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data-memory (MEM stage) port. The block accepts one request at a time from either port, runs a req/ready/rvalid handshake with the memory, and returns a one-cycle ack with read data. It drives per-port stall outputs, which the hazard logic uses to freeze the PC, the IF/ID register and the EX/MEM register. A timeout counter detects a memory that never responds.

Parameters:
ADDR_W, 32, address width of both ports and of the memory.
DATA_W, 32, data width; byte-enable width is DATA_W/8.
TIMEOUT, 16, cycles allowed in REQ or RESP before an error ack; 0 disables the timeout.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held until if_ack
if_addr  input  ADDR_W  fetch address; stable while if_req is high
if_rdata  output  DATA_W  fetched word; valid when if_ack=1
if_ack  output  1  one-cycle completion pulse for the fetch port
dm_req  input  1  data request; held until dm_ack
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_be  input  DATA_W/8  store byte enables
dm_rdata  output  DATA_W  load data; valid when dm_ack=1
dm_ack  output  1  one-cycle completion pulse for the data port
stall_if  output  1  if_req & ~if_ack (combinational)
stall_dm  output  1  dm_req & ~dm_ack (combinational)
err  output  1  pulses with the ack of a timed-out transaction
mem_req  output  1  memory request
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_be  output  DATA_W/8  memory byte enables
mem_ready  input  1  memory accepted the request in this cycle
mem_rvalid  input  1  read data valid; only legal at least 1 cycle after mem_ready
mem_rdata  input  DATA_W  read data

Behaviour:
- FSM states: IDLE, REQ, RESP, ACK. Exactly one transaction is outstanding at a time.
- IDLE:
  - If any request is high, pick a winner and latch grant, we, addr, wdata and be into the registers that drive mem_*. Then go to REQ.
  - Default arbitration: dm beats if (the MEM-stage instruction is older).
  - A fetch request has we=0 and be all ones.
  - With no request, stay in IDLE.
- REQ: mem_req=1.
  - On mem_ready, a write goes to ACK and a read goes to RESP.
  - mem_addr, mem_wdata, mem_be and mem_we stay constant in REQ.
- RESP:
  - On mem_rvalid, capture mem_rdata into the granted port's rdata register and go to ACK.
  - mem_rvalid seen in any other state is ignored.
- ACK:
  - The granted port's ack is high for exactly one cycle; rdata is valid in that cycle.
  - Next state is always IDLE.
  - A request still high in the cycle after ack is treated as a new transaction.
- Latency:
  - Read with ready at first asserting cycle and rvalid 1 cycle later: request seen at T0, mem_req at T1, rvalid at T2, ack at T3.
  - Write: request at T0, ready at T1, ack at T2.
- rdata registers hold their last value between transactions. Read data is not forwarded combinationally.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT, go to ACK with err=1 and rdata=0, and drop mem_req.
  - A late mem_rvalid after that point is ignored.
- A request deasserted before its ack is a protocol violation. The arbiter still finishes the memory transaction and pulses ack.
- Reset, including in the middle of a transaction: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, if_ack=dm_ack=0, err=0, if_rdata=dm_rdata=0, timeout counter=0, last_grant=if. No ack is produced for an aborted transaction.
- stall_if and stall_dm are combinational from the req inputs and registered acks. They are 0 during reset only if the req inputs are 0.

Optional Feature:
Macro ARB_FAIR_EN.
- Defined: when both ports request in IDLE, the port not granted last time wins (round-robin). last_grant updates on each grant.
- Not defined: fixed priority, dm over if. last_grant is not implemented.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, ready at T1, rvalid at T2 with rdata 0x00500093 -> if_ack=1 at T3 with if_rdata=0x00500093; stall_if=1 over T0–T2 and 0 at T3.
- Store: dm_req=1, dm_we=1, addr 0x2004, wdata 0xDEADBEEF, be=4'b0011, ready at T1 -> mem_we=1, mem_be=4'b0011 at T1; dm_ack at T2; if_ack stays 0.
- Contention: if_req and dm_req both high at T0, dm is a load -> dm served first, if granted in the IDLE after dm_ack. With ARB_FAIR_EN and last_grant=dm, if is served first.
- Ready backpressure: mem_ready held 0 for 5 cycles -> mem_req and mem_addr stay constant; ack 5 cycles later than the nominal latency; err=0.
- Timeout: TIMEOUT=4, mem_ready stays 0 -> mem_req high for 4 cycles; then ack with err=1 and rdata=0; a later mem_rvalid is ignored.
- Reset in RESP: reset=1 for 1 cycle while awaiting rvalid -> all outputs at reset values the next cycle; the following rvalid is ignored; no ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch port
// (if_*) and the data-memory port (dm_*). One transaction is outstanding at a
// time. It runs a req/ready/rvalid handshake with the memory and returns a
// one-cycle ack, with read data, to the port that won arbitration.
//
// Parameters
//   ADDR_W   address width of both ports and of the memory
//   DATA_W   data width; byte-enable width is DATA_W/8
//   TIMEOUT  cycles allowed in REQ+RESP before an error ack (0 = never)
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   if_req/if_addr               fetch request (held until if_ack)
//   if_rdata/if_ack              fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be               data request (held until dm_ack)
//   dm_rdata/dm_ack              load data, one-cycle completion pulse
//   stall_if/stall_dm            req & ~ack, used to freeze the pipeline
//   err                          pulses with the ack of a timed-out access
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be             request towards the memory
//   mem_ready/mem_rvalid/
//   mem_rdata                    memory accept, read-data valid, read data
//
// Build option
//   ARB_FAIR_EN  defined: round-robin between the ports when both request,
//                using a last_grant register. Undefined: fixed priority,
//                data port over fetch port.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  // data port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  // hazard / status
  output logic                stall_if,
  output logic                stall_dm,
  output logic                err,
  // memory side
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               grant_dm;   // owner of the outstanding transaction
  logic               pick_dm;    // arbitration result in IDLE
  logic               timed_out;  // leaving REQ/RESP because the budget ran out
  logic [CNT_W-1:0]   tcnt;

  // The counter holds the number of REQ/RESP cycles already completed, so the
  // budget is exhausted in the cycle where it reads TIMEOUT-1: mem_req is then
  // seen for exactly TIMEOUT cycles when the memory never answers.
  function automatic logic tmo_hit(input logic [CNT_W-1:0] cnt);
    if (TIMEOUT == 0) return 1'b0;
    return (int'(cnt) == TIMEOUT - 1);
  endfunction

  // Arbitration
`ifdef ARB_FAIR_EN
  logic last_dm;  // 1 when the data port won the previous grant

  always_comb begin
    if (if_req && dm_req) pick_dm = ~last_dm;
    else                  pick_dm = dm_req;
  end
`else
  // Data port always wins: the MEM-stage instruction is the older one.
  always_comb pick_dm = dm_req;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) state_nxt = REQ;
      end
      REQ: begin
        // A real answer from the memory takes precedence over the timeout.
        if (mem_ready) begin
          state_nxt = mem_we ? ACK : RESP;
        end else if (tmo_hit(tcnt)) begin
          state_nxt = ACK;
          timed_out = 1'b1;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_nxt = ACK;
        end else if (tmo_hit(tcnt)) begin
          state_nxt = ACK;
          timed_out = 1'b1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, request latch, timeout counter, acks and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_dm  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      tcnt      <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
`ifdef ARB_FAIR_EN
      last_dm   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            grant_dm  <= pick_dm;
            mem_we    <= pick_dm ? dm_we : 1'b0;
            mem_addr  <= pick_dm ? dm_addr : if_addr;
            mem_wdata <= pick_dm ? dm_wdata : '0;
            mem_be    <= pick_dm ? dm_be : {BE_W{1'b1}};
            tcnt      <= '0;
`ifdef ARB_FAIR_EN
            last_dm   <= pick_dm;
`endif
          end
        end
        REQ, RESP: begin
          tcnt <= tcnt + 1'b1;
        end
        default: begin
        end
      endcase

      // Acks are registered: they rise in the cycle the FSM sits in ACK.
      if (state_nxt == ACK && state != ACK) begin
        if_ack <= ~grant_dm;
        dm_ack <= grant_dm;
        err    <= timed_out;
      end

      // Read data is only ever loaded here; otherwise it holds its value.
      if (state == RESP && mem_rvalid) begin
        if (grant_dm) dm_rdata <= mem_rdata;
        else          if_rdata <= mem_rdata;
      end else if (timed_out) begin
        if (grant_dm) dm_rdata <= '0;
        else          if_rdata <= '0;
      end
    end
  end

  // Outputs derived from registered state
  assign mem_req  = (state == REQ);
  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed steps followed by randomized transactions. The bench plays the
// memory (phys_mem, written from the DUT's mem_* outputs) and keeps an
// intended-contents model (ref_mem, written from the port requests), from
// which expected read data, arbitration order and latencies are derived.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_be;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          stall_if;
  logic          stall_dm;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_if(stall_if), .stall_dm(stall_dm), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int          nvec  = 0;
  int          nfail = 0;
  logic [31:0] phys_mem [8];
  logic [31:0] ref_mem  [8];
  logic [31:0] exp_if_rd;
  logic [31:0] exp_dm_rd;
  bit          model_last_dm;
  int          sel;
  int          cnt;
  bit          dm_first;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for the grant, check the memory request, answer it after d cycles of
  // backpressure (reads: rvalid r cycles after ready), then check the ack.
  task automatic serve(input bit is_dm, input int exp_wait, input int d, input int r);
    int          w;
    logic [31:0] a;
    logic        wr;
    w = 0;
    while (mem_req !== 1'b1 && w < 50) begin
      tick();
      w++;
      if (mem_req !== 1'b1) chk("ack_single_cycle", {31'b0, if_ack | dm_ack}, 32'd0);
    end
    chk("grant_wait", w, exp_wait);
    if (mem_req !== 1'b1) return;
    a  = is_dm ? dm_addr : if_addr;
    wr = is_dm ? dm_we : 1'b0;
    model_last_dm = is_dm;
    chk("mem_we", {31'b0, mem_we}, {31'b0, wr});
    chk("mem_addr", mem_addr, a);
    chk("mem_be", {28'b0, mem_be}, is_dm ? {28'b0, dm_be} : 32'hF);
    if (wr) chk("mem_wdata", mem_wdata, dm_wdata);
    chk("stall_while_busy", {31'b0, is_dm ? stall_dm : stall_if}, 32'd1);
    for (int i = 0; i < d; i++) begin
      tick();
      chk("bp_mem_req", {31'b0, mem_req}, 32'd1);
      chk("bp_mem_addr", mem_addr, a);
    end
    mem_ready = 1'b1;
    if (mem_we === 1'b1)
      phys_mem[mem_addr[4:2]] = merge(phys_mem[mem_addr[4:2]], mem_wdata, mem_be);
    tick();
    mem_ready = 1'b0;
    if (!wr) begin
      for (int i = 1; i < r; i++) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = phys_mem[mem_addr[4:2]];
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (is_dm) exp_dm_rd = ref_mem[a[4:2]];
      else       exp_if_rd = ref_mem[a[4:2]];
    end else begin
      ref_mem[a[4:2]] = merge(ref_mem[a[4:2]], dm_wdata, dm_be);
    end
    chk("if_ack", {31'b0, if_ack}, {31'b0, !is_dm});
    chk("dm_ack", {31'b0, dm_ack}, {31'b0, is_dm});
    chk("err_normal", {31'b0, err}, 32'd0);
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("dm_rdata", dm_rdata, exp_dm_rd);
    chk("stall_at_ack", {31'b0, is_dm ? stall_dm : stall_if}, 32'd0);
    if (is_dm) dm_req = 1'b0;
    else       if_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_be = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    for (int i = 0; i < 8; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[0] = 32'h00500093;
    ref_mem[0]  = 32'h00500093;
    exp_if_rd = 0; exp_dm_rd = 0; model_last_dm = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", {28'b0, mem_be}, 0);
    chk("rst_acks", {30'b0, if_ack, dm_ack}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_rdata", if_rdata | dm_rdata, 0);
    chk("rst_stalls", {30'b0, stall_if, stall_dm}, 0);
    reset = 1'b0;
    tick();

    // Single fetch: ack at T3 with the fetched word
    if_addr = 32'h100; if_req = 1'b1;
    #1;
    chk("fetch_stall_t0", {31'b0, stall_if}, 1);
    serve(0, 1, 0, 1);
    chk("fetch_rdata_const", if_rdata, 32'h00500093);
    tick();
    chk("fetch_ack_t4", {31'b0, if_ack}, 0);
    chk("fetch_stall_t4", {31'b0, stall_if}, 0);

    // Store with partial byte enables, ack at T2
    dm_addr = 32'h2004; dm_we = 1'b1; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    dm_req = 1'b1;
    serve(1, 1, 0, 0);
    tick();

    // Load with 5 cycles of ready backpressure, reads back the merged word
    dm_addr = 32'h2004; dm_we = 1'b0;
    dm_req = 1'b1;
    serve(1, 1, 5, 1);
    chk("merged_word", dm_rdata, merge(phys_mem[1], 32'hDEADBEEF, 4'b0011) & 32'hFFFFFFFF);
    tick();

    // Contention: both request a read in the same cycle
    if_addr = 32'h1008; dm_addr = 32'h100C; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
`ifdef ARB_FAIR_EN
    dm_first = !model_last_dm;
`else
    dm_first = 1'b1;
`endif
    serve(dm_first, 1, 0, 1);
    chk("loser_stalled", {31'b0, dm_first ? stall_if : stall_dm}, 1);
    serve(!dm_first, 2, 1, 2);
    tick();

    // Timeout: memory never accepts
    if_addr = 32'h1010; if_req = 1'b1;
    tick();
    model_last_dm = 1'b0;
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("tmo_req_cycles", cnt, TO);
    chk("tmo_if_ack", {31'b0, if_ack}, 1);
    chk("tmo_err", {31'b0, err}, 1);
    chk("tmo_rdata", if_rdata, 0);
    exp_if_rd = 0;
    if_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_ack", {30'b0, if_ack, dm_ack}, 0);
    chk("late_rvalid_err", {31'b0, err}, 0);
    chk("late_rvalid_rdata", if_rdata, 0);
    tick();

    // Reset while waiting for rvalid
    dm_addr = 32'h1004; dm_we = 1'b0; dm_req = 1'b1;
    tick();
    chk("rr_mem_req", {31'b0, mem_req}, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    reset = 1'b1; dm_req = 1'b0;
    tick();
    reset = 1'b0;
    model_last_dm = 1'b0;
    exp_if_rd = 0; exp_dm_rd = 0;
    chk("rr_mem_req0", {31'b0, mem_req}, 0);
    chk("rr_mem_addr", mem_addr, 0);
    chk("rr_mem_be", {28'b0, mem_be}, 0);
    chk("rr_rdata", if_rdata | dm_rdata, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("rr_no_ack", {30'b0, if_ack, dm_ack}, 0);
    chk("rr_rvalid_ignored", dm_rdata, 0);
    tick();

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      sel      = $urandom_range(1, 3);
      if_addr  = 32'h1000 + ($urandom_range(0, 7) << 2);
      dm_addr  = 32'h1000 + ($urandom_range(0, 7) << 2);
      dm_we    = $urandom_range(0, 1);
      dm_wdata = $urandom;
      dm_be    = $urandom_range(1, 15);
      if_req   = (sel & 1) != 0;
      dm_req   = (sel & 2) != 0;
      if (sel == 3) begin
`ifdef ARB_FAIR_EN
        dm_first = !model_last_dm;
`else
        dm_first = 1'b1;
`endif
        serve(dm_first, 1, $urandom_range(0, 3), $urandom_range(1, 3));
        serve(!dm_first, 2, $urandom_range(0, 3), $urandom_range(1, 3));
      end else begin
        serve(sel == 2, 1, $urandom_range(0, 3), $urandom_range(1, 3));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
